model_ctrl: RTL and testbench

MODEL_CTRL -- requirements
Module: model_ctrl

---
 rtl/model_ctrl_pkg.sv | 12 +
 rtl/model_ctrl_if.sv | 21 ++
 rtl/model_ctrl.sv | 154 +++++++++++++++
 tb/tb_model_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/model_ctrl_pkg.sv
// Shared types for the model controller: FSM state encoding.
package model_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARMED,
    ST_STREAM,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/model_ctrl_if.sv
// Weight-load bus between host and controller plus the controller's write port to the model.
interface model_ctrl_if;

  logic [31:0] ld_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] weight_wr_data;
  logic [31:0] weight_wr_addr;
  logic        weight_wr_en;

  modport master (
    output ld_data, ld_valid,
    input  ld_ready, weight_wr_data, weight_wr_addr, weight_wr_en
  );

  modport slave (
    input  ld_data, ld_valid,
    output ld_ready, weight_wr_data, weight_wr_addr, weight_wr_en
  );

endinterface

// File: rtl/model_ctrl.sv
// Sequences weight loading and frame streaming for the classifier model.
module model_ctrl
  import model_ctrl_pkg::*;
#(
  parameter int unsigned NUM_WEIGHTS  = 450,
  parameter logic [31:0] WT_BASE_ADDR = 32'd0,
  parameter int unsigned FRAME_PIXELS = 65536,
  parameter int unsigned OUT_COUNT    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic        frame_start,
  input  logic [31:0] ld_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  output logic [31:0] weight_wr_data,
  output logic [31:0] weight_wr_addr,
  output logic        weight_wr_en,
  input  logic        src_valid,
  output logic        model_i_valid,
  input  logic        model_fifo_rd_en,
  output logic        src_rd_en,
  input  logic        cls_almost_full,
  input  logic        vertical_almost_full,
  input  logic        out_valid,
  output logic        weights_loaded,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned IDX_W = $clog2(NUM_WEIGHTS + 1);
  localparam int unsigned PIX_W = $clog2(FRAME_PIXELS + 1);
  localparam int unsigned OUT_W = $clog2(OUT_COUNT + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WEIGHTS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FRAME_PIXELS - 1);
  localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(OUT_COUNT);
  localparam logic [OUT_W-1:0] OUT_ONE  = OUT_W'(1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              loaded_q, loaded_d;
  logic              done_q, done_d;
  logic              wr_en_q, wr_en_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [31:0]       wr_addr_q, wr_addr_d;
  logic              accept;
  logic              in_stream;

  assign in_stream      = (state_q == ST_STREAM);
  assign ld_ready       = (state_q == ST_LOAD);
  assign accept         = ld_valid & ld_ready;
  assign model_i_valid  = src_valid & in_stream & ~cls_almost_full & ~vertical_almost_full;
  assign src_rd_en      = model_fifo_rd_en & in_stream;
  assign busy           = (state_q == ST_LOAD) | (state_q == ST_STREAM) | (state_q == ST_DRAIN);
  assign weights_loaded = loaded_q;
  assign frame_done     = done_q;
  assign weight_wr_en   = wr_en_q;
  assign weight_wr_data = wr_data_q;
  assign weight_wr_addr = wr_addr_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pix_d     = pix_q;
    out_d     = out_q;
    loaded_d  = loaded_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;

    if (accept) begin
      wr_en_d   = 1'b1;
      wr_data_d = ld_data;
      wr_addr_d = WT_BASE_ADDR + 32'(idx_q);
      idx_d     = idx_q + IDX_ONE;
    end

    // Output beats count in both STREAM and DRAIN so early results are not lost.
    if ((state_q == ST_STREAM || state_q == ST_DRAIN) && out_valid && out_q != OUT_MAX)
      out_d = out_q + OUT_ONE;

    if (src_rd_en)
      pix_d = pix_q + PIX_ONE;

    unique case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        if (accept && idx_q == IDX_LAST) begin
          state_d  = ST_ARMED;
          loaded_d = 1'b1;
        end
      end
      ST_ARMED: begin
        if (load_start) begin
          state_d  = ST_LOAD;
          loaded_d = 1'b0;
          idx_d    = '0;
        end else if (frame_start) begin
          state_d = ST_STREAM;
          pix_d   = '0;
          out_d   = '0;
        end
      end
      ST_STREAM: begin
        if (src_rd_en && pix_q == PIX_LAST)
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_q == OUT_MAX) begin
          state_d = ST_ARMED;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pix_q     <= '0;
      out_q     <= '0;
      loaded_q  <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= WT_BASE_ADDR;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pix_q     <= pix_d;
      out_q     <= out_d;
      loaded_q  <= loaded_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
    end
  end

endmodule

// File: tb/tb_model_ctrl.sv
// Randomized and directed bench for model_ctrl against a transaction-level reference model.
module tb_model_ctrl;

  localparam int unsigned NW   = 4;
  localparam int unsigned FP   = 8;
  localparam int unsigned OC   = 2;
  localparam logic [31:0] BASE = 32'd16;

  logic clk = 1'b0;
  logic rst, load_start, frame_start, src_valid, model_i_valid, model_fifo_rd_en;
  logic src_rd_en, cls_almost_full, vertical_almost_full, out_valid;
  logic weights_loaded, busy, frame_done;

  model_ctrl_if wbus ();

  always #5 clk = ~clk;

  model_ctrl #(
    .NUM_WEIGHTS (NW),
    .WT_BASE_ADDR(BASE),
    .FRAME_PIXELS(FP),
    .OUT_COUNT   (OC)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .load_start          (load_start),
    .frame_start         (frame_start),
    .ld_data             (wbus.ld_data),
    .ld_valid            (wbus.ld_valid),
    .ld_ready            (wbus.ld_ready),
    .weight_wr_data      (wbus.weight_wr_data),
    .weight_wr_addr      (wbus.weight_wr_addr),
    .weight_wr_en        (wbus.weight_wr_en),
    .src_valid           (src_valid),
    .model_i_valid       (model_i_valid),
    .model_fifo_rd_en    (model_fifo_rd_en),
    .src_rd_en           (src_rd_en),
    .cls_almost_full     (cls_almost_full),
    .vertical_almost_full(vertical_almost_full),
    .out_valid           (out_valid),
    .weights_loaded      (weights_loaded),
    .busy                (busy),
    .frame_done          (frame_done)
  );

  typedef enum {P_IDLE, P_LOAD, P_ARMED, P_STREAM, P_DRAIN} phase_e;

  // Reference model: phase plus per-load word count and per-frame pixel/result tallies.
  phase_e      m_ph;
  int unsigned m_words, m_pix, m_outs;
  bit          m_loaded, m_done, m_wr;
  logic [31:0] m_wr_data, m_wr_addr;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned done_seen, miv_low, drain_cycles;
  logic [31:0] wr_log[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_words = 0; m_pix = 0; m_outs = 0;
    m_loaded = 0; m_done = 0; m_wr = 0; m_wr_data = '0; m_wr_addr = BASE;
  endtask

  task automatic model_step();
    phase_e      ph;
    int unsigned outs0;
    bit          acc, rd;
    ph    = m_ph;
    outs0 = m_outs;
    if (rst) begin
      model_reset();
      return;
    end
    acc    = (ph == P_LOAD) && wbus.ld_valid;
    rd     = (ph == P_STREAM) && model_fifo_rd_en;
    m_wr   = acc;
    m_done = 0;
    if (acc) begin
      m_wr_data = wbus.ld_data;
      m_wr_addr = BASE + m_words;
      m_words++;
    end
    if ((ph == P_STREAM || ph == P_DRAIN) && out_valid && m_outs < OC) m_outs++;
    if (rd) m_pix++;
    case (ph)
      P_IDLE:  if (load_start) begin m_ph = P_LOAD; m_words = 0; end
      P_LOAD:  if (acc && m_words == NW) begin m_ph = P_ARMED; m_loaded = 1; end
      P_ARMED: if (load_start) begin
                 m_ph = P_LOAD; m_loaded = 0; m_words = 0;
               end else if (frame_start) begin
                 m_ph = P_STREAM; m_pix = 0; m_outs = 0;
               end
      P_STREAM: if (rd && m_pix == FP) m_ph = P_DRAIN;
      P_DRAIN:  if (outs0 == OC) begin m_ph = P_ARMED; m_done = 1; end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    check_eq("ld_ready", wbus.ld_ready, m_ph == P_LOAD);
    check_eq("wr_en", wbus.weight_wr_en, m_wr);
    check_eq("wr_data", wbus.weight_wr_data, m_wr_data);
    check_eq("wr_addr", wbus.weight_wr_addr, m_wr_addr);
    check_eq("i_valid", model_i_valid,
             src_valid && m_ph == P_STREAM && !cls_almost_full && !vertical_almost_full);
    check_eq("src_rd_en", src_rd_en, model_fifo_rd_en && m_ph == P_STREAM);
    check_eq("busy", busy, m_ph == P_LOAD || m_ph == P_STREAM || m_ph == P_DRAIN);
    check_eq("loaded", weights_loaded, m_loaded);
    check_eq("frame_done", frame_done, m_done);
    if (wbus.weight_wr_en === 1'b1) wr_log.push_back(wbus.weight_wr_addr);
    if (frame_done === 1'b1) done_seen++;
    if (model_i_valid === 1'b0) miv_low++;
    if (m_ph == P_DRAIN) drain_cycles++;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_start = 0; frame_start = 0; wbus.ld_valid = 0; wbus.ld_data = '0;
    src_valid = 0; model_fifo_rd_en = 0; cls_almost_full = 0;
    vertical_almost_full = 0; out_valid = 0; rst = 0;
  endtask

  task automatic load_words(input int unsigned n);
    load_start = 1; tick(); load_start = 0;
    for (int unsigned i = 0; i < n; i++) begin
      wbus.ld_valid = 0; tick();
      wbus.ld_valid = 1; wbus.ld_data = $urandom; tick();
    end
    wbus.ld_valid = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    model_reset();
    tick(); tick();
    rst = 0;
    frame_start = 1; tick(); frame_start = 0;   // ignored in IDLE

    // Gapped load of four words
    wr_log.delete();
    load_words(NW);
    tick(); tick();
    check_eq("wr_count", wr_log.size(), NW);
    for (int unsigned k = 0; k < NW && k < wr_log.size(); k++)
      check_eq("wr_addr_seq", wr_log[k], BASE + k);
    check_eq("loaded_after_d", weights_loaded, 1);

    // Frame with a five-cycle backpressure window
    frame_start = 1; tick(); frame_start = 0;
    src_valid = 1; model_fifo_rd_en = 1;
    for (int i = 0; i < 3; i++) tick();
    cls_almost_full = 1; model_fifo_rd_en = 0; miv_low = 0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("afull_low_cycles", miv_low, 5);
    cls_almost_full = 0; model_fifo_rd_en = 1;
    for (int i = 0; i < 5; i++) tick();
    model_fifo_rd_en = 0; src_valid = 0; done_seen = 0;
    out_valid = 1; tick(); tick(); out_valid = 0;
    for (int i = 0; i < 3; i++) tick();
    check_eq("done_pulses", done_seen, 1);
    check_eq("armed_not_busy", busy, 0);

    // Results arrive before the last pixel: DRAIN lasts one cycle
    frame_start = 1; tick(); frame_start = 0;
    src_valid = 1; model_fifo_rd_en = 1; out_valid = 1;
    tick(); tick(); out_valid = 0;
    for (int i = 0; i < 5; i++) tick();
    drain_cycles = 0; done_seen = 0;
    tick();                                      // eighth pixel
    model_fifo_rd_en = 0;
    tick();                                      // DRAIN
    check_eq("early_done", frame_done, 1);
    tick();
    check_eq("drain_len", drain_cycles, 1);
    check_eq("early_done_pulses", done_seen, 1);

    // load_start beats frame_start in ARMED
    load_start = 1; frame_start = 1; tick();
    load_start = 0; frame_start = 0;
    check_eq("tie_loaded", weights_loaded, 0);
    check_eq("tie_ready", wbus.ld_ready, 1);

    // Reset after two words, then reload from the base address
    wr_log.delete();
    for (int i = 0; i < 2; i++) begin
      wbus.ld_valid = 1; wbus.ld_data = $urandom; tick();
    end
    rst = 1; tick(); rst = 0; wbus.ld_valid = 0;
    tick(); tick();
    check_eq("abort_writes", wr_log.size(), 2);
    wr_log.delete();
    load_words(NW);
    tick();
    check_eq("reload_first_addr", wr_log.size() > 0 ? wr_log[0] : 32'hffff_ffff, BASE);
    check_eq("reload_loaded", weights_loaded, 1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      rst                  = ($urandom_range(0, 299) == 0);
      load_start           = ($urandom_range(0, 59) == 0);
      frame_start          = ($urandom_range(0, 7) == 0);
      wbus.ld_valid        = $urandom_range(0, 1);
      wbus.ld_data         = $urandom;
      src_valid            = ($urandom_range(0, 3) != 0);
      model_fifo_rd_en     = ($urandom_range(0, 3) != 0);
      cls_almost_full      = ($urandom_range(0, 7) == 0);
      vertical_almost_full = ($urandom_range(0, 7) == 0);
      out_valid            = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
